// File: rtl/key_conditioner_pkg.sv
// Shared definitions for the key conditioner: repeat FSM encoding and
// parameter helper functions used by the top and the per-channel logic.
package key_conditioner_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    RPT   = 2'd2
  } rpt_state_t;

  function automatic int ms_cyc(input int clk_hz);
    return clk_hz / 1000;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Raw pin value of an idle (unpressed) button for the given polarity.
  function automatic logic released_raw(input int active_low);
    return (active_low != 0);
  endfunction

endpackage

// File: rtl/key_conditioner_ch.sv
// One button channel: 2-flop synchroniser, debounce, press/release edge
// detect and hold-to-auto-repeat FSM.
module key_conditioner_ch
  import key_conditioner_pkg::*;
#(
  parameter int DB_CYC     = 4,
  parameter int RD_CYC     = 20,
  parameter int RR_CYC     = 5,
  parameter int ACTIVE_LOW = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_repeat
);

  localparam int DC_W   = $clog2(DB_CYC + 1);
  localparam int RC_W   = $clog2(max_int(RD_CYC, RR_CYC) + 1);
  localparam logic [DC_W-1:0] DC_TERM = DC_W'(DB_CYC - 1);
  localparam logic [RC_W-1:0] RD_TERM = RC_W'((RD_CYC > 0) ? RD_CYC - 1 : 0);
  localparam logic [RC_W-1:0] RR_TERM = RC_W'(RR_CYC - 1);
  localparam logic RAW_IDLE = released_raw(ACTIVE_LOW);

  logic            r_sync1;
  logic            r_sync2;
  logic            w_pressed;
  logic            r_level;
  logic            r_level_d;
  logic            r_press;
  logic            r_release;
  logic [DC_W-1:0] r_dc;
  rpt_state_t      r_state;
  rpt_state_t      w_state_next;
  logic [RC_W-1:0] r_rc;
  logic [RC_W-1:0] w_rc_next;
  logic            w_repeat;

  // Synchroniser idles at the released level so reset never looks like a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= RAW_IDLE;
      r_sync2 <= RAW_IDLE;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_pressed = r_sync2 ^ RAW_IDLE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dc    <= '0;
      r_level <= 1'b0;
    end else if (w_pressed == r_level) begin
      r_dc <= '0;
    end else if (r_dc == DC_TERM) begin
      r_dc    <= '0;
      r_level <= w_pressed;
    end else begin
      r_dc <= r_dc + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level_d <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_level_d <= r_level;
      r_press   <= r_level & ~r_level_d;
      r_release <= ~r_level & r_level_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_rc    <= '0;
    end else begin
      r_state <= w_state_next;
      r_rc    <= w_rc_next;
    end
  end

  // A released key always forces IDLE with no pulse, whatever the state.
  always_comb begin
    w_state_next = r_state;
    w_rc_next    = r_rc;
    w_repeat     = 1'b0;
    if (!r_level) begin
      w_state_next = IDLE;
      w_rc_next    = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_press) begin
            w_repeat     = 1'b1;
            w_rc_next    = '0;
            w_state_next = (RD_CYC == 0) ? RPT : DELAY;
          end
        end
        DELAY: begin
          if (r_rc == RD_TERM) begin
            w_repeat     = 1'b1;
            w_rc_next    = '0;
            w_state_next = RPT;
          end else begin
            w_rc_next = r_rc + 1'b1;
          end
        end
        RPT: begin
          if (r_rc == RR_TERM) begin
            w_repeat  = 1'b1;
            w_rc_next = '0;
          end else begin
            w_rc_next = r_rc + 1'b1;
          end
        end
        default: begin
          w_state_next = IDLE;
          w_rc_next    = '0;
        end
      endcase
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_repeat  = w_repeat;

endmodule

// File: rtl/key_conditioner.sv
// Conditions N_KEYS raw buttons into debounced levels, press/release pulses
// and auto-repeat pulses; each channel is an independent copy.
module key_conditioner
  import key_conditioner_pkg::*;
#(
  parameter int N_KEYS          = 4,
  parameter int CLK_HZ          = 50_000_000,
  parameter int DEBOUNCE_MS     = 10,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [N_KEYS-1:0] SW,
  output logic [N_KEYS-1:0] KEY_LEVEL,
  output logic [N_KEYS-1:0] KEY_PRESS,
  output logic [N_KEYS-1:0] KEY_RELEASE,
  output logic [N_KEYS-1:0] KEY_REPEAT
);

  localparam int MS_CYC = ms_cyc(CLK_HZ);
  localparam int DB_CYC = DEBOUNCE_MS * MS_CYC;
  localparam int RD_CYC = REPEAT_DELAY_MS * MS_CYC;
  localparam int RR_CYC = REPEAT_RATE_MS * MS_CYC;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    key_conditioner_ch #(
      .DB_CYC    (DB_CYC),
      .RD_CYC    (RD_CYC),
      .RR_CYC    (RR_CYC),
      .ACTIVE_LOW(ACTIVE_LOW)
    ) u_ch (
      .clk      (CLK),
      .rst      (RST),
      .i_raw    (SW[g]),
      .o_level  (KEY_LEVEL[g]),
      .o_press  (KEY_PRESS[g]),
      .o_release(KEY_RELEASE[g]),
      .o_repeat (KEY_REPEAT[g])
    );
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with MS_CYC=1, debounce 4, repeat
// delay 20 and repeat rate 5 cycles, active-low buttons.
module tb_key_conditioner;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] SW;
  logic [3:0] KEY_LEVEL;
  logic [3:0] KEY_PRESS;
  logic [3:0] KEY_RELEASE;
  logic [3:0] KEY_REPEAT;

  int testsRun    = 0;
  int testsFailed = 0;

  typedef struct {
    logic [3:0] sw;
    logic [3:0] lvl;
    logic [3:0] prs;
    logic [3:0] rel;
    logic [3:0] rpt;
  } vec_t;

  vec_t vecs[16];

  key_conditioner #(
    .N_KEYS         (4),
    .CLK_HZ         (1000),
    .DEBOUNCE_MS    (4),
    .REPEAT_DELAY_MS(20),
    .REPEAT_RATE_MS (5),
    .ACTIVE_LOW     (1)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .SW         (SW),
    .KEY_LEVEL  (KEY_LEVEL),
    .KEY_PRESS  (KEY_PRESS),
    .KEY_RELEASE(KEY_RELEASE),
    .KEY_REPEAT (KEY_REPEAT)
  );

  always #5 CLK = ~CLK;

  // Advance one clock; outputs are then stable for sampling and inputs may change.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] sw, input int cycles);
    SW = sw;
    for (int i = 0; i < cycles; i++) tick();
  endtask

  task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkCount(input string name, input int act, input int exp);
    testsRun++;
    if (act != exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  initial begin
    int firstPress;
    int pressCount;
    int earlyLevel;
    int repCycles[$];
    int expRep[8];

    // Clean press on key 0 (rows 0-7), then release (rows 8-15).
    for (int i = 0; i < 8; i++) vecs[i] = '{4'hE, 4'h0, 4'h0, 4'h0, 4'h0};
    vecs[5] = '{4'hE, 4'h1, 4'h0, 4'h0, 4'h0};
    vecs[6] = '{4'hE, 4'h1, 4'h1, 4'h0, 4'h1};
    vecs[7] = '{4'hE, 4'h1, 4'h0, 4'h0, 4'h0};
    for (int i = 8; i < 13; i++) vecs[i] = '{4'hF, 4'h1, 4'h0, 4'h0, 4'h0};
    vecs[13] = '{4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
    vecs[14] = '{4'hF, 4'h0, 4'h0, 4'h1, 4'h0};
    vecs[15] = '{4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
    expRep = '{7, 27, 32, 37, 42, 47, 52, 57};

    // Reset with all buttons released.
    RST = 1'b1;
    SW  = 4'hF;
    tick(); tick(); tick();
    checkOutput("reset_level",   KEY_LEVEL,   4'h0);
    checkOutput("reset_press",   KEY_PRESS,   4'h0);
    checkOutput("reset_release", KEY_RELEASE, 4'h0);
    checkOutput("reset_repeat",  KEY_REPEAT,  4'h0);
    RST = 1'b0;
    for (int c = 0; c < 50; c++) begin
      tick();
      checkOutput("idle_quiet", KEY_LEVEL | KEY_PRESS | KEY_RELEASE | KEY_REPEAT, 4'h0);
    end

    for (int i = 0; i < 16; i++) begin
      SW = vecs[i].sw;
      tick();
      checkOutput($sformatf("vec%0d_level", i),   KEY_LEVEL,   vecs[i].lvl);
      checkOutput($sformatf("vec%0d_press", i),   KEY_PRESS,   vecs[i].prs);
      checkOutput($sformatf("vec%0d_release", i), KEY_RELEASE, vecs[i].rel);
      checkOutput($sformatf("vec%0d_repeat", i),  KEY_REPEAT,  vecs[i].rpt);
    end
    applyStimulus(4'hF, 5);

    // Bounce on key 1: 2-cycle stretches, last toggle (to pressed) at t=20.
    firstPress = -1;
    pressCount = 0;
    earlyLevel = 0;
    for (int t = 0; t < 45; t++) begin
      if (t <= 20 && (t % 2) == 0) SW[1] = ((t / 2) % 2 == 0) ? 1'b0 : 1'b1;
      tick();
      if (KEY_PRESS[1]) begin
        pressCount++;
        if (firstPress < 0) firstPress = t + 1;
      end
      if (KEY_LEVEL[1] && (t + 1) < 26) earlyLevel++;
    end
    checkCount("bounce_press_count", pressCount, 1);
    checkCount("bounce_press_cycle", firstPress, 27);
    checkCount("bounce_early_level", earlyLevel, 0);
    applyStimulus(4'hF, 15);

    // Auto-repeat on key 2: held for 55 cycles, level high on cycles 6..60.
    repCycles.delete();
    pressCount = 0;
    for (int t = 0; t < 80; t++) begin
      if (t == 0)  SW[2] = 1'b0;
      if (t == 55) SW[2] = 1'b1;
      tick();
      if (KEY_REPEAT[2]) repCycles.push_back(t + 1);
      if (KEY_PRESS[2]) pressCount++;
    end
    checkCount("repeat_count", repCycles.size(), 8);
    checkCount("repeat_press_count", pressCount, 1);
    for (int i = 0; i < 8; i++) begin
      if (i < repCycles.size()) checkCount($sformatf("repeat_cycle%0d", i), repCycles[i], expRep[i]);
    end
    applyStimulus(4'hF, 5);

    // Simultaneous press and release of all keys.
    applyStimulus(4'h0, 6);
    checkOutput("simul_press_early", KEY_PRESS, 4'h0);
    checkOutput("simul_level",       KEY_LEVEL, 4'hF);
    tick();
    checkOutput("simul_press",  KEY_PRESS,  4'hF);
    checkOutput("simul_repeat", KEY_REPEAT, 4'hF);
    tick();
    checkOutput("simul_press_end", KEY_PRESS, 4'h0);
    applyStimulus(4'hF, 7);
    checkOutput("simul_release", KEY_RELEASE, 4'hF);
    tick();
    checkOutput("simul_release_end", KEY_RELEASE, 4'h0);
    applyStimulus(4'hF, 5);

    // Reset during repeat on key 3, key still held afterwards.
    applyStimulus(4'h7, 35);
    checkOutput("prereset_level", KEY_LEVEL, 4'h8);
    RST = 1'b1;
    #1;
    checkOutput("midrst_level",   KEY_LEVEL,   4'h0);
    checkOutput("midrst_press",   KEY_PRESS,   4'h0);
    checkOutput("midrst_release", KEY_RELEASE, 4'h0);
    checkOutput("midrst_repeat",  KEY_REPEAT,  4'h0);
    tick(); tick(); tick();
    RST = 1'b0;
    repCycles.delete();
    pressCount = 0;
    firstPress = -1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (KEY_REPEAT[3]) repCycles.push_back(c);
      if (KEY_PRESS[3]) begin
        pressCount++;
        if (firstPress < 0) firstPress = c;
      end
    end
    checkCount("rst_press_count", pressCount, 1);
    checkCount("rst_press_cycle", firstPress, 7);
    checkCount("rst_repeat_count", repCycles.size(), 2);
    if (repCycles.size() == 2) begin
      checkCount("rst_repeat_first",  repCycles[0], 7);
      checkCount("rst_repeat_second", repCycles[1], 27);
    end
    applyStimulus(4'hF, 10);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
